// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts one instruction per cycle from EX, runs loads/stores
// over a req/ack handshake with a wait timeout, resolves branches and registers WB results.
module mem_stage_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 22,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_rd,
   input  logic              in_wr,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [DATA_W-1:0] in_sprite_data,
   input  logic              in_sprite_sel,
   input  logic              in_mem_alu_sel,
   input  logic              in_branch,
   input  logic [2:0]        in_cond,
   input  logic              flag_ov,
   input  logic              flag_neg,
   input  logic              flag_zero,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_mem_result,
   output logic [DATA_W-1:0] out_sprite_result,
   output logic              out_mem_alu_sel,
   output logic              branch_taken,
   output logic              mem_err
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stall_q, stall_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_mem_result_q, out_mem_result_d;
   logic [DATA_W-1:0] out_sprite_result_q, out_sprite_result_d;
   logic              out_mem_alu_sel_q, out_mem_alu_sel_d;
   logic              branch_taken_q, branch_taken_d;
   logic              mem_err_q, mem_err_d;
   // Fields of a memory instruction parked until its handshake completes
   logic [DATA_W-1:0] hold_sprite_q, hold_sprite_d;
   logic              hold_sel_q, hold_sel_d;
   logic              hold_br_q, hold_br_d;
   logic              hold_rd_q, hold_rd_d;

   logic              cond_ok;
   logic [DATA_W-1:0] sprite_pick;

   always_comb begin
      cond_ok = 1'b0;
      case (in_cond)
         3'b000: cond_ok = ~flag_zero;
         3'b001: cond_ok = flag_zero;
         3'b010: cond_ok = ~flag_zero & ~flag_neg;
         3'b011: cond_ok = flag_neg;
         3'b100: cond_ok = ~flag_neg;
         3'b101: cond_ok = flag_neg | flag_zero;
         3'b110: cond_ok = flag_ov;
         default: cond_ok = 1'b1;
      endcase
   end

   assign sprite_pick = in_sprite_sel ? in_wdata : in_sprite_data;

   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      stall_d             = stall_q;
      mem_req_d           = mem_req_q;
      mem_we_d            = mem_we_q;
      mem_addr_d          = mem_addr_q;
      mem_wdata_d         = mem_wdata_q;
      out_valid_d         = 1'b0;
      out_mem_result_d    = out_mem_result_q;
      out_sprite_result_d = out_sprite_result_q;
      out_mem_alu_sel_d   = out_mem_alu_sel_q;
      branch_taken_d      = branch_taken_q;
      mem_err_d           = mem_err_q;
      hold_sprite_d       = hold_sprite_q;
      hold_sel_d          = hold_sel_q;
      hold_br_d           = hold_br_q;
      hold_rd_d           = hold_rd_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_rd || in_wr) begin
                  state_d       = S_WAIT;
                  cnt_d         = '0;
                  stall_d       = 1'b1;
                  mem_req_d     = 1'b1;
                  mem_we_d      = in_wr & ~in_rd;
                  mem_addr_d    = in_addr;
                  mem_wdata_d   = in_wdata;
                  hold_sprite_d = sprite_pick;
                  hold_sel_d    = in_mem_alu_sel;
                  hold_br_d     = in_branch & cond_ok;
                  hold_rd_d     = in_rd;
               end else begin
                  out_valid_d         = 1'b1;
                  out_mem_result_d    = '0;
                  out_sprite_result_d = sprite_pick;
                  out_mem_alu_sel_d   = in_mem_alu_sel;
                  branch_taken_d      = in_branch & cond_ok;
               end
            end
         end
         S_WAIT: begin
            if (mem_ack || cnt_q == CNT_LAST) begin
               state_d             = S_IDLE;
               cnt_d               = '0;
               stall_d             = 1'b0;
               mem_req_d           = 1'b0;
               out_valid_d         = 1'b1;
               out_sprite_result_d = hold_sprite_q;
               out_mem_alu_sel_d   = hold_sel_q;
               // An ack arriving on the final allowed cycle still counts as success
               if (mem_ack) begin
                  out_mem_result_d = hold_rd_q ? mem_rdata : '0;
                  branch_taken_d   = hold_br_q;
               end else begin
                  out_mem_result_d = '0;
                  branch_taken_d   = 1'b0;
                  mem_err_d        = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= S_IDLE;
         cnt_q               <= '0;
         stall_q             <= 1'b0;
         mem_req_q           <= 1'b0;
         mem_we_q            <= 1'b0;
         mem_addr_q          <= '0;
         mem_wdata_q         <= '0;
         out_valid_q         <= 1'b0;
         out_mem_result_q    <= '0;
         out_sprite_result_q <= '0;
         out_mem_alu_sel_q   <= 1'b0;
         branch_taken_q      <= 1'b0;
         mem_err_q           <= 1'b0;
         hold_sprite_q       <= '0;
         hold_sel_q          <= 1'b0;
         hold_br_q           <= 1'b0;
         hold_rd_q           <= 1'b0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         stall_q             <= stall_d;
         mem_req_q           <= mem_req_d;
         mem_we_q            <= mem_we_d;
         mem_addr_q          <= mem_addr_d;
         mem_wdata_q         <= mem_wdata_d;
         out_valid_q         <= out_valid_d;
         out_mem_result_q    <= out_mem_result_d;
         out_sprite_result_q <= out_sprite_result_d;
         out_mem_alu_sel_q   <= out_mem_alu_sel_d;
         branch_taken_q      <= branch_taken_d;
         mem_err_q           <= mem_err_d;
         hold_sprite_q       <= hold_sprite_d;
         hold_sel_q          <= hold_sel_d;
         hold_br_q           <= hold_br_d;
         hold_rd_q           <= hold_rd_d;
      end
   end

   assign stall             = stall_q;
   assign mem_req           = mem_req_q;
   assign mem_we            = mem_we_q;
   assign mem_addr          = mem_addr_q;
   assign mem_wdata         = mem_wdata_q;
   assign out_valid         = out_valid_q;
   assign out_mem_result    = out_mem_result_q;
   assign out_sprite_result = out_sprite_result_q;
   assign out_mem_alu_sel   = out_mem_alu_sel_q;
   assign branch_taken      = branch_taken_q;
   assign mem_err           = mem_err_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Parametrised memory-stage controller for the CPU pipeline. It accepts one instruction per cycle from EX and issues loads and stores to main memory over a multi-cycle req/ack handshake, holding the pipeline while a cache miss is outstanding. It resolves the branch condition from the ALU flags and selects the sprite/ALU and mem/ALU results. All outputs are registered toward WB, with a wait-timeout error path.

Parameters:
DATA_W, 32, data path width (mem data, sprite data, results)
ADDR_W, 22, memory word-address width
MAX_WAIT, 15, maximum cycles mem_req may stay unacknowledged before abort (≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX stage presents an instruction
in_rd  in  1  instruction is a load
in_wr  in  1  instruction is a store (in_rd&in_wr is illegal; treated as load)
in_addr  in  ADDR_W  memory address
in_wdata  in  DATA_W  store data; also the sprite_sel=1 source
in_sprite_data  in  DATA_W  sprite unit data
in_sprite_sel  in  1  1: sprite_result=in_wdata, 0: in_sprite_data
in_mem_alu_sel  in  1  WB select, passed through
in_branch  in  1  instruction is a branch
in_cond  in  3  branch condition
flag_ov, flag_neg, flag_zero  in  1 each  ALU flags
stall  out  1  EX must hold its instruction
mem_req  out  1  memory request
mem_we  out  1  1=write
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  request complete (1-cycle pulse)
out_valid  out  1  WB-bound result valid (1-cycle pulse per instruction)
out_mem_result  out  DATA_W  load data (0 for non-loads)
out_sprite_result  out  DATA_W  selected sprite/ALU data
out_mem_alu_sel  out  1  registered in_mem_alu_sel
branch_taken  out  1  registered branch decision, qualified by out_valid
mem_err  out  1  sticky: a request timed out

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, mem_err 0. Reset mid-request drops mem_req immediately; no out_valid.
- States: IDLE, WAIT.
- IDLE, in_valid=1, no rd/wr: capture the instruction. Next cycle out_valid=1 with results (latency 1). Back-to-back accepts allowed; stall=0.
- IDLE, in_valid=1 with rd or wr: capture all fields, go to WAIT. Next cycle mem_req=1, mem_we=in_wr, with addr/wdata held stable until done.
- stall = (state==WAIT), registered. In the accept cycle stall is 0, so EX advances. EX must not present a new valid instruction in that cycle's successor until stall falls.
- WAIT, mem_ack=1:
  - Deassert mem_req next cycle and return to IDLE.
  - out_valid=1 next cycle; out_mem_result=mem_rdata for a load, 0 for a store.
  - mem_ack in the first WAIT cycle gives 2-cycle latency.
- WAIT, no ack: counter increments. When the counter reaches MAX_WAIT without ack:
  - drop mem_req and set mem_err=1 (sticky until rst);
  - emit out_valid with out_mem_result=0, branch_taken=0;
  - return to IDLE.
- mem_ack while in IDLE is ignored.
- Branch: evaluated at accept from the input-cycle flags, registered. branch_taken = in_branch & cond(in_cond):
  - 000 !Z; 001 Z; 010 !Z&!N; 011 N; 100 !N; 101 N|Z; 110 V; 111 1.
  - Non-branch gives 0.
- out_sprite_result and out_mem_alu_sel are registered at accept and presented with out_valid.
- Outputs hold their last values between out_valid pulses.

Test Plan:
- ALU op: in_valid, in_sprite_sel=0, in_sprite_data=0xDEADBEEF -> next cycle out_valid=1, out_sprite_result=0xDEADBEEF, stall=0; back-to-back second op also completes 1 cycle later.
- Load hit: in_rd, addr=0x3FFFFF, mem_ack in first WAIT cycle with rdata=0x12345678 -> mem_req for 1 cycle, stall 1 cycle, out_valid 2 cycles after accept, out_mem_result=0x12345678.
- Store miss: in_wr, wdata=0xA5A5A5A5, ack after 6 WAIT cycles -> mem_we=1, mem_wdata stable 6+ cycles, out_mem_result=0, mem_err=0.
- Timeout: load, never ack, MAX_WAIT=15 -> mem_req drops after 15 cycles, mem_err=1 sticky, out_valid=1 with out_mem_result=0.
- Branch sweep: all 8 in_cond × 8 flag combinations -> branch_taken matches the table; in_branch=0 -> 0.
- Reset mid-WAIT: assert rst during an outstanding load -> mem_req, stall, out_valid all 0 immediately; a later mem_ack produces no out_valid.
